// File: rtl/rename_pkg.sv
// rename_pkg: shared widths, index/map types and identity-map helper for the register alias table.
package rename_pkg;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  localparam int ARCH_W = 5;
  localparam int PHYS_W = 6;
  typedef logic [ARCH_W-1:0] arch_idx_t;
  typedef logic [PHYS_W-1:0] phys_idx_t;
  typedef phys_idx_t [ARCH_REGS-1:0] map_t;
  localparam arch_idx_t ZERO_REG = 5'd31;
  function automatic map_t identity_map();
    map_t m;
    for (int i = 0; i < ARCH_REGS; i++) m[i] = phys_idx_t'(i);
    return m;
  endfunction
endpackage

// File: rtl/rat_bank.sv
// rat_bank: 32x6 mapping flop array with one write port, bulk load, NR combinational read ports and identity reset.
module rat_bank
  import rename_pkg::*;
#(
  parameter int NR = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  arch_idx_t             waddr,
  input  phys_idx_t             wdata,
  input  logic                  load,
  input  map_t                  load_map,
  input  arch_idx_t [NR-1:0]    raddr,
  output phys_idx_t [NR-1:0]    rdata,
  output map_t                  map
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) map <= identity_map();
    else if (load) map <= load_map;
    else if (we && waddr != ZERO_REG) map[waddr] <= wdata;
  for (genvar r = 0; r < NR; r++) begin : g_rd
    assign rdata[r] = raddr[r] == ZERO_REG ? phys_idx_t'(ZERO_REG) : map[raddr[r]];
  end
endmodule

// File: rtl/rename_table.sv
// rename_table: speculative + committed register alias tables for the rename stage.
// RENAME_RECOVERY_EN adds a flush input that reloads the speculative map from the committed one.
module rename_table
  import rename_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  arch_idx_t arch_rs1,
  input  arch_idx_t arch_rs2,
  output phys_idx_t phys_rs1,
  output phys_idx_t phys_rs2,
  input  logic      rename_en,
  input  arch_idx_t arch_rd,
  input  phys_idx_t new_phys_rd,
  output phys_idx_t old_phys_rd,
`ifdef RENAME_RECOVERY_EN
  input  logic      flush,
`endif
  input  logic      commit_en,
  input  arch_idx_t commit_arch_rd,
  input  phys_idx_t commit_phys_rd
);
  map_t spec_map, comm_map, spec_load_map;
  phys_idx_t [2:0] spec_rd;
  phys_idx_t [0:0] comm_rd;
  logic spec_load;
  logic unused_comm;
`ifdef RENAME_RECOVERY_EN
  // flush sees the committed map including this edge's retirement
  map_t comm_next;
  always_comb begin
    comm_next = comm_map;
    if (commit_en && commit_arch_rd != ZERO_REG) comm_next[commit_arch_rd] = commit_phys_rd;
  end
  assign spec_load = flush;
  assign spec_load_map = comm_next;
  assign unused_comm = ^comm_rd;
`else
  assign spec_load = 1'b0;
  assign spec_load_map = '0;
  assign unused_comm = ^{comm_rd, comm_map};
`endif
  rat_bank #(.NR(3)) u_spec (
    .clk(clk), .reset(reset),
    .we(rename_en), .waddr(arch_rd), .wdata(new_phys_rd),
    .load(spec_load), .load_map(spec_load_map),
    .raddr({arch_rd, arch_rs2, arch_rs1}), .rdata(spec_rd), .map(spec_map)
  );
  rat_bank #(.NR(1)) u_comm (
    .clk(clk), .reset(reset),
    .we(commit_en), .waddr(commit_arch_rd), .wdata(commit_phys_rd),
    .load(1'b0), .load_map('0),
    .raddr(commit_arch_rd), .rdata(comm_rd), .map(comm_map)
  );
  assign phys_rs1 = spec_rd[0];
  assign phys_rs2 = spec_rd[1];
  assign old_phys_rd = spec_rd[2];
  logic unused_spec;
  assign unused_spec = ^spec_map;
endmodule

// File: tb/tb_rename_table.sv
// tb_rename_table: randomized check of rename_table against an array-based alias-table model.
module tb_rename_table;
  logic clk = 0, reset = 0;
  logic [4:0] arch_rs1 = 0, arch_rs2 = 0, arch_rd = 0, commit_arch_rd = 0;
  logic [5:0] phys_rs1, phys_rs2, old_phys_rd, new_phys_rd = 0, commit_phys_rd = 0;
  logic rename_en = 0, commit_en = 0, flush = 0;
  int spec_m[32], comm_m[32];
  int n_checks = 0, n_fail = 0;

  rename_table dut (
    .clk(clk), .reset(reset),
    .arch_rs1(arch_rs1), .arch_rs2(arch_rs2), .phys_rs1(phys_rs1), .phys_rs2(phys_rs2),
    .rename_en(rename_en), .arch_rd(arch_rd), .new_phys_rd(new_phys_rd), .old_phys_rd(old_phys_rd),
`ifdef RENAME_RECOVERY_EN
    .flush(flush),
`endif
    .commit_en(commit_en), .commit_arch_rd(commit_arch_rd), .commit_phys_rd(commit_phys_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int look(input int a);
    return a == 31 ? 31 : spec_m[a];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      spec_m[i] = i;
      comm_m[i] = i;
    end
  endfunction

  task automatic step();
    #1;
    check("phys_rs1", phys_rs1, look(arch_rs1));
    check("phys_rs2", phys_rs2, look(arch_rs2));
    check("old_phys_rd", old_phys_rd, look(arch_rd));
    @(posedge clk);
    if (commit_en && commit_arch_rd != 31) comm_m[commit_arch_rd] = commit_phys_rd;
`ifdef RENAME_RECOVERY_EN
    if (flush) spec_m = comm_m;
    else
`endif
    if (rename_en && arch_rd != 31) spec_m[arch_rd] = new_phys_rd;
    @(negedge clk);
    rename_en = 0;
    commit_en = 0;
    flush = 0;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      arch_rs1 = 5'(i);
      #1 check(tag, phys_rs1, look(i));
      check({tag, "_comm"}, dut.u_comm.map[i], comm_m[i]);
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1;
    arch_rs1 = 2; arch_rs2 = 3;
    #1 check("reset_rs1", phys_rs1, 2);
    check("reset_rs2", phys_rs2, 3);
    check_all("reset_id");
    // rename 2->40 while reading arch 2 in the same cycle
    arch_rs1 = 2; rename_en = 1; arch_rd = 2; new_phys_rd = 40;
    #1 check("no_bypass", phys_rs1, 2);
    check("old_before", old_phys_rd, 2);
    step();
    #1 check("after_rename", phys_rs1, 40);
    // XZR writes ignored, reads 31
    rename_en = 1; arch_rd = 31; new_phys_rd = 50;
    step();
    arch_rs1 = 31;
    #1 check("xzr_read", phys_rs1, 31);
    // commit 2->40 with simultaneous rename 5->41
    commit_en = 1; commit_arch_rd = 2; commit_phys_rd = 40;
    rename_en = 1; arch_rd = 5; new_phys_rd = 41;
    step();
    arch_rs1 = 2; arch_rs2 = 5;
    #1 check("spec2_kept", phys_rs1, 40);
    check("rename5", phys_rs2, 41);
    check("comm2", dut.u_comm.map[2], 40);
    check("comm5", dut.u_comm.map[5], 5);
`ifdef RENAME_RECOVERY_EN
    rename_en = 1; arch_rd = 3; new_phys_rd = 42;
    step();
    flush = 1; rename_en = 1; arch_rd = 7; new_phys_rd = 43;
    step();
    arch_rs1 = 2; arch_rs2 = 3;
    #1 check("flush_rs1", phys_rs1, 40);
    check("flush_rs2", phys_rs2, 3);
    arch_rs1 = 5; arch_rs2 = 7;
    #1 check("flush_5", phys_rs1, 5);
    check("flush_drop", phys_rs2, 7);
`endif
    // randomized traffic, biased toward XZR and shared indices
    for (int n = 0; n < 400; n++) begin
      arch_rs1 = 5'($urandom);
      arch_rs2 = 5'($urandom);
      arch_rd = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
      new_phys_rd = 6'($urandom);
      rename_en = 1'($urandom);
      commit_en = 1'($urandom);
      commit_arch_rd = ($urandom_range(0, 3) == 0) ? arch_rd : 5'($urandom);
      commit_phys_rd = 6'($urandom);
      flush = ($urandom_range(0, 15) == 0);
`ifndef RENAME_RECOVERY_EN
      flush = 0;
`endif
      step();
      begin
        int k = $urandom_range(0, 31);
        check("rand_comm", dut.u_comm.map[k], comm_m[k]);
      end
    end
    check_all("pre_reset");
    // async reset lands mid-cycle with writes pending
    rename_en = 1; arch_rd = 4; new_phys_rd = 60;
    commit_en = 1; commit_arch_rd = 4; commit_phys_rd = 61;
    #2 reset = 0;
    model_reset();
    #1 check_all("async_reset");
    @(negedge clk);
    reset = 1;
    rename_en = 1; arch_rd = 4; new_phys_rd = 60;
    step();
    arch_rs1 = 4;
    #1 check("post_reset_rename", phys_rs1, 60);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
